// File: rtl/decode_pkg.sv
// Shared types and encoding constants for the LEGv8-subset decode queue.
package decode_pkg;

  typedef enum logic [3:0] {
    OP_ADDI, OP_ADDS, OP_BLT, OP_B, OP_CBZ, OP_LDUR,
    OP_LSL, OP_LSR, OP_MUL, OP_STUR, OP_SUBS, OP_INV
  } op_t;

  localparam logic [5:0]  OPC_B    = 6'h05;
  localparam logic [7:0]  OPC_CBZ  = 8'hB4;
  localparam logic [7:0]  OPC_BLT  = 8'h54;
  localparam logic [4:0]  BLT_RD   = 5'h0B;
  localparam logic [9:0]  OPC_ADDI = 10'h244;
  localparam logic [10:0] OPC_LSR  = 11'h69A;
  localparam logic [10:0] OPC_LSL  = 11'h69B;
  localparam logic [10:0] OPC_SUBS = 11'h758;
  localparam logic [10:0] OPC_STUR = 11'h7C0;
  localparam logic [10:0] OPC_LDUR = 11'h7C2;
  localparam logic [10:0] OPC_ADDS = 11'h558;
  localparam logic [10:0] OPC_MUL  = 11'h4D8;
  localparam logic [5:0]  MUL_SHAMT = 6'h1F;

  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b011;

  typedef struct packed {
    op_t        op;
    logic       illegal;
    logic [5:0] shamt;
    logic [4:0] rm;
    logic [4:0] rn;
    logic [4:0] rd;
    logic [2:0] aluc;
  } dec_rec_t;

  localparam dec_rec_t DEC_RESET = '{op: OP_INV, illegal: 1'b0, shamt: 6'h0,
                                     rm: 5'h0, rn: 5'h0, rd: 5'h0, aluc: 3'h0};

endpackage

// File: rtl/insn_decode_comb.sv
// Purely combinational decode of one instruction word into a record plus extended immediate.
module insn_decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst,
  output dec_rec_t        rec,
  output logic [XLEN-1:0] imm
);

  op_t op;

  // Decode order matters: earlier, shorter opcode fields win over later ones.
  always_comb begin
    op = OP_INV;
    if (inst[31:26] == OPC_B)                                op = OP_B;
    else if (inst[31:24] == OPC_CBZ)                         op = OP_CBZ;
    else if (inst[31:24] == OPC_BLT && inst[4:0] == BLT_RD)  op = OP_BLT;
    else if (inst[31:22] == OPC_ADDI)                        op = OP_ADDI;
    else begin
      case (inst[31:21])
        OPC_LSR:  op = OP_LSR;
        OPC_LSL:  op = OP_LSL;
        OPC_SUBS: op = OP_SUBS;
        OPC_STUR: op = OP_STUR;
        OPC_LDUR: op = OP_LDUR;
        OPC_ADDS: op = OP_ADDS;
        OPC_MUL:  op = (inst[15:10] == MUL_SHAMT) ? OP_MUL : OP_INV;
        default:  op = OP_INV;
      endcase
    end
  end

  always_comb begin
    case (op)
      OP_ADDI:          imm = XLEN'(inst[21:10]);
      OP_B:             imm = {{(XLEN-26){inst[25]}}, inst[25:0]};
      OP_CBZ, OP_BLT:   imm = {{(XLEN-19){inst[23]}}, inst[23:5]};
      OP_LDUR, OP_STUR: imm = {{(XLEN-9){inst[20]}}, inst[20:12]};
      OP_LSL, OP_LSR:   imm = XLEN'(inst[15:10]);
      default:          imm = '0;
    endcase
  end

  assign rec.op      = op;
  assign rec.illegal = (op == OP_INV);
  assign rec.shamt   = inst[15:10];
  assign rec.rm      = inst[20:16];
  assign rec.rn      = inst[9:5];
  assign rec.rd      = inst[4:0];
  assign rec.aluc    = (op == OP_SUBS) ? ALUC_SUB : ALUC_ADD;

endmodule

// File: rtl/decode_queue.sv
// Decode stage: decodes on push, buffers decoded records in a DEPTH-entry FIFO toward execute.
module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int PC_W  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_op,
  output logic [XLEN-1:0]            out_imm,
  output logic [5:0]                 out_shamt,
  output logic [4:0]                 out_rm,
  output logic [4:0]                 out_rn,
  output logic [4:0]                 out_rd,
  output logic [2:0]                 out_aluc,
  output logic [PC_W-1:0]            out_pc,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                illegal_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  dec_rec_t        dec_rec;
  logic [XLEN-1:0] dec_imm;

  dec_rec_t        mem_rec [DEPTH];
  logic [XLEN-1:0] mem_imm [DEPTH];
  logic [PC_W-1:0] mem_pc  [DEPTH];

  logic [AW-1:0] wptr, rptr;
  logic          push, pop;

  insn_decode_comb #(.XLEN(XLEN)) u_dec (
    .inst (in_inst),
    .rec  (dec_rec),
    .imm  (dec_imm)
  );

  // No push-through when full: readiness ignores a same-cycle pop.
  assign in_ready  = !rst && !flush && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_rec[i] <= DEC_RESET;
        mem_imm[i] <= '0;
        mem_pc[i]  <= '0;
      end
    end else if (push) begin
      mem_rec[wptr] <= dec_rec;
      mem_imm[wptr] <= dec_imm;
      mem_pc[wptr]  <= in_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_cnt <= '0;
    else if (push && dec_rec.illegal && illegal_cnt != 16'hFFFF)
      illegal_cnt <= illegal_cnt + 16'd1;
  end

  assign out_op      = mem_rec[rptr].op;
  assign out_illegal = mem_rec[rptr].illegal;
  assign out_shamt   = mem_rec[rptr].shamt;
  assign out_rm      = mem_rec[rptr].rm;
  assign out_rn      = mem_rec[rptr].rn;
  assign out_rd      = mem_rec[rptr].rd;
  assign out_aluc    = mem_rec[rptr].aluc;
  assign out_imm     = mem_imm[rptr];
  assign out_pc      = mem_pc[rptr];

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed cases plus random traffic against a queue-based reference model.
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 64;
  localparam int PC_W  = 64;

  localparam int ADDI = 0, ADDS = 1, BLT = 2, B = 3, CBZ = 4, LDUR = 5;
  localparam int LSL = 6, LSR = 7, MUL = 8, STUR = 9, SUBS = 10, INV = 11;

  logic        clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_inst = 0;
  logic [63:0] in_pc = 0;
  logic        in_ready, out_valid, out_illegal;
  logic [3:0]  out_op;
  logic [63:0] out_imm, out_pc;
  logic [5:0]  out_shamt;
  logic [4:0]  out_rm, out_rn, out_rd;
  logic [2:0]  out_aluc;
  logic [2:0]  count;
  logic [15:0] illegal_cnt;

  int checks = 0, failures = 0;

  typedef struct {
    int          op;
    logic [63:0] imm;
    logic [5:0]  shamt;
    logic [4:0]  rm, rn, rd;
    logic [2:0]  aluc;
    logic [63:0] pc;
    bit          illegal;
  } ent_t;

  ent_t mq[$];
  int   mcnt = 0;

  decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_imm(out_imm),
    .out_shamt(out_shamt), .out_rm(out_rm), .out_rn(out_rn), .out_rd(out_rd),
    .out_aluc(out_aluc), .out_pc(out_pc), .out_illegal(out_illegal),
    .count(count), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t ref_decode(logic [31:0] w, logic [63:0] pc);
    ent_t        e;
    int unsigned u;
    longint      v;
    u = w;
    e.op = INV; e.imm = 0; e.pc = pc;
    e.shamt = w[15:10]; e.rm = w[20:16]; e.rn = w[9:5]; e.rd = w[4:0];
    if ((u >> 26) == 5) begin
      e.op = B;
      v = u % (1 << 26);
      if (v >= (1 << 25)) v -= (1 << 26);
      e.imm = v;
    end else if ((u >> 24) == 'hB4 || ((u >> 24) == 'h54 && u % 32 == 11)) begin
      e.op = ((u >> 24) == 'hB4) ? CBZ : BLT;
      v = (u >> 5) % (1 << 19);
      if (v >= (1 << 18)) v -= (1 << 19);
      e.imm = v;
    end else if ((u >> 22) == 'h244) begin
      e.op = ADDI;
      e.imm = (u >> 10) % 4096;
    end else begin
      case (u >> 21)
        'h69A: begin e.op = LSR; e.imm = e.shamt; end
        'h69B: begin e.op = LSL; e.imm = e.shamt; end
        'h758: e.op = SUBS;
        'h558: e.op = ADDS;
        'h4D8: if (e.shamt == 31) e.op = MUL;
        'h7C0, 'h7C2: begin
          e.op = ((u >> 21) == 'h7C0) ? STUR : LDUR;
          v = (u >> 12) % 512;
          if (v >= 256) v -= 512;
          e.imm = v;
        end
        default: e.op = INV;
      endcase
    end
    e.illegal = (e.op == INV);
    e.aluc = (e.op == SUBS) ? 3'b011 : 3'b010;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0: r[31:26] = 6'h05;
      1: r[31:24] = 8'hB4;
      2: begin r[31:24] = 8'h54; if ($urandom_range(0, 1) == 1) r[4:0] = 5'h0B; end
      3: r[31:22] = 10'h244;
      4: r[31:21] = 11'h69A;
      5: r[31:21] = 11'h69B;
      6: r[31:21] = 11'h758;
      7: r[31:21] = 11'h7C0;
      8: r[31:21] = 11'h7C2;
      9: r[31:21] = 11'h558;
      10: begin r[31:21] = 11'h4D8; if ($urandom_range(0, 1) == 1) r[15:10] = 6'h1F; end
      default: ;
    endcase
    return r;
  endfunction

  // Reference model: advances on each clock edge from the inputs, cleared by reset.
  always @(posedge clk or posedge rst) begin
    bit   m_rdy, m_push, m_pop;
    ent_t e;
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      m_rdy  = (mq.size() < DEPTH) && !flush;
      m_push = in_valid && m_rdy;
      m_pop  = (mq.size() > 0) && out_ready;
      e = ref_decode(in_inst, in_pc);
      if (flush) mq.delete();
      else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          mq.push_back(e);
          if (e.illegal && mcnt < 65535) mcnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("count", count, mq.size());
    check("in_ready", in_ready, !rst && mq.size() < DEPTH && !flush);
    check("out_valid", out_valid, mq.size() > 0);
    check("illegal_cnt", illegal_cnt, mcnt);
    if (mq.size() > 0) begin
      check("out_op", out_op, mq[0].op);
      check("out_imm", out_imm, mq[0].imm);
      check("out_shamt", out_shamt, mq[0].shamt);
      check("out_rm", out_rm, mq[0].rm);
      check("out_rn", out_rn, mq[0].rn);
      check("out_rd", out_rd, mq[0].rd);
      check("out_aluc", out_aluc, mq[0].aluc);
      check("out_pc", out_pc, mq[0].pc);
      check("out_illegal", out_illegal, mq[0].illegal);
    end
  end

  task automatic drive(bit v, logic [31:0] w, logic [63:0] pc, bit ordy, bit fl);
    in_valid = v; in_inst = w; in_pc = pc; out_ready = ordy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_illegal_cnt"}, illegal_cnt, 0);
    check({tag, "_out_op"}, out_op, INV);
    check({tag, "_out_imm"}, out_imm, 0);
    check({tag, "_out_pc"}, out_pc, 0);
    check({tag, "_out_illegal"}, out_illegal, 0);
  endtask

  initial begin
    logic [31:0] w;
    #1 rst = 1;
    #1 check_reset_outputs("rst0");
    @(posedge clk);
    #1 rst = 0;

    drive(1, 32'h91001441, 64'h100, 0, 0);
    check("addi_op", out_op, ADDI);
    check("addi_imm", out_imm, 5);
    check("addi_rn", out_rn, 2);
    check("addi_rd", out_rd, 1);
    check("addi_aluc", out_aluc, 3'b010);
    check("addi_pc", out_pc, 64'h100);
    drive(0, 0, 0, 1, 0);

    drive(1, 32'h17FFFFFF, 64'h104, 1, 0);
    check("b_op", out_op, B);
    check("b_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);

    drive(1, 32'h9B007C00, 64'h108, 1, 0);
    check("mul_op", out_op, MUL);
    check("mul_illegal", out_illegal, 0);
    drive(1, 32'h9B000000, 64'h10C, 1, 0);
    check("mulbad_op", out_op, INV);
    check("mulbad_illegal", out_illegal, 1);
    check("mulbad_cnt", illegal_cnt, 1);
    drive(0, 0, 0, 1, 0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        w = 32'h91000000 | (i << 10);
        drive(1, w, 64'h1000 + r * 16 + i, 0, 0);
      end
      check("full_in_ready", in_ready, 0);
      if (r == 0) drive(1, 32'h91003C00, 64'hDEAD, 0, 0);
      check("full_count", count, 4);
      check("full_head", out_pc, 64'h1000 + r * 16);
      for (int i = 0; i < 4; i++) begin
        check("drain_pc", out_pc, 64'h1000 + r * 16 + i);
        check("drain_imm", out_imm, i);
        drive(0, 0, 0, 1, 0);
      end
      check("drain_empty", out_valid, 0);
    end

    for (int i = 0; i < 3; i++) drive(1, 32'h91000400, 64'h200 + i, 0, 0);
    check("preflush_count", count, 3);
    drive(1, 32'h91003C00, 64'h2FF, 0, 1);
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 0);
    drive(0, 0, 0, 1, 0);
    check("flush_dropped", out_valid, 0);

    drive(1, 32'h9B000000, 64'h400, 0, 0);
    drive(1, 32'h91000400, 64'h404, 0, 0);
    check("prerst_count", count, 2);
    #2 rst = 1;
    #1 check_reset_outputs("async_rst");
    @(posedge clk);
    #1 rst = 0;
    drive(1, 32'h91000800, 64'h300, 0, 0);
    check("postrst_valid", out_valid, 1);
    check("postrst_pc", out_pc, 64'h300);
    check("postrst_imm", out_imm, 2);
    drive(0, 0, 0, 1, 0);

    for (int n = 0; n < 800; n++) begin
      drive($urandom_range(0, 3) != 0, rand_inst(), {$urandom, $urandom},
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end
    drive(0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
